lsu_mem_ctrl: RTL and testbench

- Load/store control stage sitting directly upstream of the word-addressed DPI-backed data memory.
- Accepts one load/store request from EXU (valid/ready), checks alignment, legality and range, then drives the memory's single-cycle strobe interface.
- Captures memory read data one cycle later and presents the result to WBU (valid/ready).
- One transaction in flight; no buffering beyond the captured result.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_decode.sv | 43 ++++
 rtl/lsu_mem_ctrl.sv | 112 +++++++++++
 tb/tb_lsu_mem_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: funct3 encodings, fault codes, control states.
// Used by the strobe-interface control path and the cache path.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FLT_NONE  = 2'b00;
  localparam logic [1:0] FLT_MIS   = 2'b01;
  localparam logic [1:0] FLT_ILL   = 2'b10;
  localparam logic [1:0] FLT_RANGE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_CAPTURE,
    ST_RESP
  } lsu_state_e;

  // Request fields carried from accept to the WBU response.
  typedef struct packed {
    logic        is_store;
    logic [4:0]  rd;
    logic [1:0]  fault;
    logic [31:0] fault_addr;
  } lsu_req_t;

endpackage

// File: rtl/lsu_decode.sv
// Access decode: size/sign sideband bits and prioritised fault code.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module lsu_decode
  import lsu_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter logic [31:0] ADDR_SIZE = 32'h0400_0000
) (
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  output logic        suffix_b,
  output logic        suffix_h,
  output logic        sext,
  output logic [1:0]  fault
);

  logic illegal;
  logic misaligned;
  logic in_range;

  always_comb begin
    suffix_b = (funct3[1:0] == 2'b00);
    suffix_h = (funct3[1:0] == 2'b01);
    sext     = ~is_store & ~funct3[2];

    if (is_store) illegal = !(funct3 inside {F3_B, F3_H, F3_W});
    else          illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

    misaligned = suffix_h ? addr[0] : (suffix_b ? 1'b0 : (addr[1:0] != 2'b00));

    // 33-bit compare keeps the window end from wrapping past 0xFFFF_FFFF.
    in_range = ({1'b0, addr} >= {1'b0, ADDR_BASE}) &&
               ({1'b0, addr} <  ({1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE}));

    if (illegal)         fault = FLT_ILL;
    else if (misaligned) fault = FLT_MIS;
    else if (!in_range)  fault = FLT_RANGE;
    else                 fault = FLT_NONE;
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store control in front of the single-cycle strobe data memory.
// Latency accept->out_valid: load 3, store 2, fault 1; one transaction in flight.
// Backpressure: in_ready only in IDLE; out_ready=0 holds RESP without re-accessing memory.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter logic [31:0] ADDR_SIZE = 32'h0400_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_suffix_b,
  output logic        mem_suffix_h,
  output logic        mem_sext,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic [4:0]  out_rd,
  output logic        out_is_store,
  output logic [1:0]  out_fault,
  output logic [31:0] out_fault_addr
);

  lsu_state_e  state_q, state_d;
  lsu_req_t    req_q;
  logic [31:0] rdata_q;
  logic        dec_b, dec_h, dec_sext;
  logic [1:0]  dec_fault;
  logic        accept;

  lsu_decode #(
    .ADDR_BASE (ADDR_BASE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_decode (
    .is_store (in_is_store),
    .funct3   (in_funct3),
    .addr     (in_addr),
    .suffix_b (dec_b),
    .suffix_h (dec_h),
    .sext     (dec_sext),
    .fault    (dec_fault)
  );

  assign accept = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = (dec_fault != FLT_NONE) ? ST_RESP : ST_ACCESS;
      ST_ACCESS:  state_d = req_q.is_store ? ST_RESP : ST_CAPTURE;
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP:    if (out_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Strobes decode straight from state so reset removes them without a clock.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_RESP);
  assign mem_ren   = (state_q == ST_ACCESS) & ~req_q.is_store;
  assign mem_wen   = (state_q == ST_ACCESS) &  req_q.is_store;

  assign out_rdata      = rdata_q;
  assign out_rd         = req_q.rd;
  assign out_is_store   = req_q.is_store;
  assign out_fault      = req_q.fault;
  assign out_fault_addr = req_q.fault_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      rdata_q      <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_suffix_b <= 1'b0;
      mem_suffix_h <= 1'b0;
      mem_sext     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q.is_store   <= in_is_store;
        req_q.rd         <= in_rd;
        req_q.fault      <= dec_fault;
        req_q.fault_addr <= (dec_fault != FLT_NONE) ? in_addr : 32'h0;
        rdata_q          <= '0;
        // Memory-side sideband only moves for requests that will reach ACCESS.
        if (dec_fault == FLT_NONE) begin
          mem_addr     <= in_addr;
          mem_wdata    <= in_is_store ? in_wdata : 32'h0;
          mem_suffix_b <= dec_b;
          mem_suffix_h <= dec_h;
          mem_sext     <= dec_sext;
        end
      end
      if (state_q == ST_CAPTURE) rdata_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed cases plus random traffic against a byte-level reference memory.
module tb_lsu_mem_ctrl;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SIZE = 32'h0400_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_is_store = 1'b0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [31:0] in_addr = 32'd0;
  logic [31:0] in_wdata = 32'd0;
  logic [4:0]  in_rd = 5'd0;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_suffix_b, mem_suffix_h, mem_sext;
  logic [31:0] mem_rdata = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;
  logic        out_is_store;
  logic [1:0]  out_fault;
  logic [31:0] out_fault_addr;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_BASE(BASE), .ADDR_SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_suffix_b(mem_suffix_b), .mem_suffix_h(mem_suffix_h), .mem_sext(mem_sext),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_rd(out_rd),
    .out_is_store(out_is_store), .out_fault(out_fault), .out_fault_addr(out_fault_addr)
  );

  int tests = 0;
  int errs  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory seen through the DUT strobes, and the reference model's own copy.
  logic [7:0] dmem [logic [31:0]];
  logic [7:0] rmem [logic [31:0]];

  function automatic logic [7:0] dbyte(input logic [31:0] a);
    return dmem.exists(a) ? dmem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] rbyte(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] raw, input int n, input bit sx);
    if (n == 1) return sx ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
    if (n == 2) return sx ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
    return raw;
  endfunction

  int          ren_cnt = 0, wen_cnt = 0, both_cnt = 0;
  logic [31:0] last_addr = 0, last_wdata = 0;
  logic        last_b = 0, last_h = 0, last_sx = 0;

  // Memory responder: acts mid-cycle so read data is stable across the capture edge.
  initial forever begin
    int n;
    logic [31:0] raw;
    @(negedge clk);
    if (mem_ren && mem_wen) both_cnt++;
    if (mem_ren || mem_wen) begin
      last_addr = mem_addr; last_wdata = mem_wdata;
      last_b = mem_suffix_b; last_h = mem_suffix_h; last_sx = mem_sext;
      n = mem_suffix_b ? 1 : (mem_suffix_h ? 2 : 4);
      if (mem_ren) begin
        ren_cnt++;
        raw = 0;
        for (int i = 0; i < n; i++) raw[8*i +: 8] = dbyte(mem_addr + 32'(i));
        mem_rdata = ext(raw, n, mem_sext);
      end
      if (mem_wen) begin
        wen_cnt++;
        for (int i = 0; i < n; i++) dmem[mem_addr + 32'(i)] = mem_wdata[8*i +: 8];
      end
    end
  end

  function automatic int access_bytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
  endfunction

  function automatic logic [1:0] ref_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    longint unsigned la, lo, hi;
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) return 2'b10;
    if ((a % access_bytes(f3)) != 0) return 2'b01;
    la = a; lo = BASE; hi = lo + SIZE;
    if (la < lo || la >= hi) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] raw = 0;
    int n = access_bytes(f3);
    for (int i = 0; i < n; i++) raw[8*i +: 8] = rbyte(a + 32'(i));
    return ext(raw, n, f3[2] == 1'b0);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    dmem[a] = b;
    rmem[a] = b;
  endtask

  task automatic txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int stall, input string tag);
    logic [1:0]  ef;
    logic [31:0] erd;
    logic [4:0]  rd;
    int exp_lat, lat, r0, w0;
    rd  = 5'($urandom_range(0, 31));
    ef  = ref_fault(st, f3, a);
    erd = (!st && ef == 2'b00) ? ref_load(f3, a) : 32'h0;
    exp_lat = (ef != 2'b00) ? 1 : (st ? 2 : 3);

    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1; in_is_store = st; in_funct3 = f3; in_addr = a; in_wdata = wd; in_rd = rd;
    r0 = ren_cnt; w0 = wen_cnt;
    @(posedge clk); #1;
    in_valid = 0; in_wdata = $urandom();
    if (st && ef == 2'b00)
      for (int i = 0; i < access_bytes(f3); i++) rmem[a + 32'(i)] = wd[8*i +: 8];

    lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));

    for (int s = 0; s <= stall; s++) begin
      if (s == stall) out_ready = 1;
      check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
      check({tag, "_rdata"}, out_rdata, erd);
      check({tag, "_fault"}, 32'(out_fault), 32'(ef));
      check({tag, "_fault_addr"}, out_fault_addr, (ef != 2'b00) ? a : 32'h0);
      check({tag, "_rd"}, 32'(out_rd), 32'(rd));
      check({tag, "_is_store"}, 32'(out_is_store), 32'(st));
      @(posedge clk); #1;
    end
    out_ready = 0;
    check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ren_count"}, 32'(ren_cnt - r0), 32'(!st && ef == 2'b00));
    check({tag, "_wen_count"}, 32'(wen_cnt - w0), 32'(st && ef == 2'b00));
    if (ef == 2'b00) begin
      check({tag, "_mem_addr"}, last_addr, a);
      check({tag, "_mem_wdata"}, last_wdata, st ? wd : 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mem_ren", 32'(mem_ren), 32'd0);
    check("rst_mem_wen", 32'(mem_wen), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_out_fault", 32'(out_fault), 32'd0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 128; i++) preload(BASE + 32'(i), 8'($urandom()));
    for (int i = 1; i <= 8; i++) preload(BASE + SIZE - 32'(i), 8'($urandom()));

    // Sign-extended byte load.
    preload(BASE + 32'd3, 8'h80);
    txn(0, 3'b000, BASE + 32'd3, 32'h0, 0, "lb");
    check("lb_rdata_const", out_rdata, 32'hFFFF_FF80);
    check("lb_suffix_b", 32'(last_b), 32'd1);
    check("lb_sext", 32'(last_sx), 32'd1);

    // Halfword store: data goes out unshifted.
    txn(1, 3'b001, BASE + 32'd2, 32'h1234_ABCD, 0, "sh");
    check("sh_suffix_h", 32'(last_h), 32'd1);
    check("sh_suffix_b", 32'(last_b), 32'd0);

    txn(0, 3'b010, BASE + 32'd6, 32'h0, 0, "lw_mis");
    check("lw_mis_code", 32'(out_fault), 32'd1);
    txn(0, 3'b011, BASE + 32'd5, 32'h0, 0, "ill_over_mis");
    check("ill_over_mis_code", 32'(out_fault), 32'd2);
    txn(0, 3'b010, 32'h8400_0000, 32'h0, 0, "lw_range_end");
    txn(0, 3'b100, 32'hFFFF_FFFF, 32'h0, 0, "lbu_top");
    check("lbu_top_code", 32'(out_fault), 32'd3);

    // Unsigned halfword under WBU backpressure.
    preload(BASE + 32'h20, 8'hEF);
    preload(BASE + 32'h21, 8'hBE);
    txn(0, 3'b101, BASE + 32'h20, 32'h0, 5, "lhu_stall");
    check("lhu_stall_rdata_const", out_rdata, 32'h0000_BEEF);

    // Reset mid-store: strobe must fall without a clock edge.
    begin
      int w0;
      @(negedge clk);
      in_valid = 1; in_is_store = 1; in_funct3 = 3'b010; in_addr = BASE + 32'h40;
      in_wdata = 32'hDEAD_BEEF; in_rd = 5'd7;
      w0 = wen_cnt;
      @(posedge clk); #1;
      in_valid = 0;
      check("rst_mid_wen_high", 32'(mem_wen), 32'd1);
      rst_n = 0;
      #1;
      check("rst_mid_wen_async", 32'(mem_wen), 32'd0);
      check("rst_mid_ren_async", 32'(mem_ren), 32'd0);
      @(negedge clk);
      rst_n = 1;
      #1;
      check("rst_mid_in_ready", 32'(in_ready), 32'd1);
      check("rst_mid_out_valid", 32'(out_valid), 32'd0);
      check("rst_mid_no_write", 32'(wen_cnt - w0), 32'd0);
    end

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      int mode;
      mode = $urandom_range(0, 3);
      case (mode)
        0, 1:    a = BASE + 32'($urandom_range(0, 127));
        2:       a = BASE + SIZE - 32'd8 + 32'($urandom_range(0, 15));
        default: a = $urandom();
      endcase
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom(),
          $urandom_range(0, 3), "rnd");
    end

    check("strobe_overlap", 32'(both_cnt), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
